// File: rtl/cpu_test_loader_pkg.sv
// Shared types and constants for the CPU test loader.
package cpu_test_loader_pkg;

    localparam int unsigned IMEM_WORDS  = 512;
    localparam int unsigned DUMP_MAX    = 1024;
    localparam int unsigned IMEM_STRIDE = 4;
    localparam int unsigned DMEM_STRIDE = 8;

    localparam int unsigned ADDR_W  = 64;
    localparam int unsigned IDATA_W = 32;
    localparam int unsigned DDATA_W = 64;
    localparam int unsigned CYC_W   = 32;
    localparam int unsigned DUMP_W  = 11;
    localparam int unsigned WCNT_W  = 10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_RUN,
        ST_DREQ,
        ST_DWAIT,
        ST_DOUT,
        ST_DONE
    } state_e;

endpackage

// File: rtl/cpu_test_loader_if.sv
// Program stream, dump stream and CPU external memory ports of the loader.
interface cpu_test_loader_if;
    import cpu_test_loader_pkg::*;

    logic               s_valid;
    logic               s_ready;
    logic [IDATA_W-1:0] s_data;
    logic               s_last;

    logic               m_valid;
    logic               m_ready;
    logic [DDATA_W-1:0] m_data;
    logic               m_last;

    logic [ADDR_W-1:0]  imem_addr;
    logic               imem_wen;
    logic               imem_ren;
    logic [IDATA_W-1:0] imem_wdata;

    logic [ADDR_W-1:0]  dmem_addr;
    logic               dmem_wen;
    logic               dmem_ren;
    logic [DDATA_W-1:0] dmem_wdata;
    logic [DDATA_W-1:0] dmem_rdata;

    modport master (
        input  s_valid, s_data, s_last, m_ready, dmem_rdata,
        output s_ready, m_valid, m_data, m_last,
               imem_addr, imem_wen, imem_ren, imem_wdata,
               dmem_addr, dmem_wen, dmem_ren, dmem_wdata
    );

    modport slave (
        output s_valid, s_data, s_last, m_ready, dmem_rdata,
        input  s_ready, m_valid, m_data, m_last,
               imem_addr, imem_wen, imem_ren, imem_wdata,
               dmem_addr, dmem_wen, dmem_ren, dmem_wdata
    );

endinterface

// File: rtl/cpu_test_loader_run_timer.sv
// Loadable 32-bit down-counter; expired_o marks the final enabled cycle.
module cpu_test_loader_run_timer
    import cpu_test_loader_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [CYC_W-1:0] load_val_i,
    input  logic             dec_i,
    output logic             expired_o
);

    logic [CYC_W-1:0] count_q;
    logic [CYC_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (dec_i && (count_q != '0)) begin
            count_d = count_q - CYC_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired_o = (count_q <= CYC_W'(1));

endmodule

// File: rtl/cpu_test_loader.sv
// Loads a program into imem, runs the CPU for a set number of cycles,
// then streams back the requested data-memory words.
module cpu_test_loader
    import cpu_test_loader_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [CYC_W-1:0]  run_cycles,
    input  logic [DUMP_W-1:0] dump_words,
    output logic              cpu_enable,
    output logic              busy,
    output logic              done,
    output logic              load_err,
    cpu_test_loader_if.master bus
);

    state_e             state_q, state_d;
    logic [CYC_W-1:0]   run_cycles_q, run_cycles_d;
    logic [DUMP_W-1:0]  dump_words_q, dump_words_d;
    logic [WCNT_W-1:0]  word_cnt_q, word_cnt_d;
    logic [DUMP_W-1:0]  dump_idx_q, dump_idx_d;
    logic [DDATA_W-1:0] m_data_q, m_data_d;
    logic               load_err_q, load_err_d;

    logic               timer_load;
    logic [CYC_W-1:0]   timer_val;
    logic               timer_expired;
    logic               s_ready_c;
    logic               s_hs_c;
    logic               word_fits_c;
    logic               dump_last_c;

    // Stream words are discarded while reset is asserted
    assign s_ready_c   = (state_q == ST_LOAD) && !rst;
    assign s_hs_c      = s_ready_c && bus.s_valid;
    assign word_fits_c = (word_cnt_q < WCNT_W'(IMEM_WORDS));
    assign dump_last_c = (dump_idx_q == (dump_words_q - DUMP_W'(1)));

    cpu_test_loader_run_timer u_run_timer (
        .clk        (clk),
        .rst        (rst),
        .load_i     (timer_load),
        .load_val_i (timer_val),
        .dec_i      (state_q == ST_RUN),
        .expired_o  (timer_expired)
    );

    always_comb begin
        state_d      = state_q;
        run_cycles_d = run_cycles_q;
        dump_words_d = dump_words_q;
        word_cnt_d   = word_cnt_q;
        dump_idx_d   = dump_idx_q;
        m_data_d     = m_data_q;
        load_err_d   = load_err_q;
        timer_load   = 1'b0;
        timer_val    = run_cycles_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    run_cycles_d = run_cycles;
                    dump_words_d = (dump_words > DUMP_W'(DUMP_MAX)) ? DUMP_W'(DUMP_MAX) : dump_words;
                    word_cnt_d   = '0;
                    dump_idx_d   = '0;
                    load_err_d   = 1'b0;
                    timer_load   = 1'b1;
                    timer_val    = '0;
                    state_d      = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (s_hs_c) begin
                    if (word_fits_c) begin
                        word_cnt_d = word_cnt_q + WCNT_W'(1);
                    end else begin
                        load_err_d = 1'b1;
                    end
                    if (bus.s_last) begin
                        if (run_cycles_q != '0) begin
                            timer_load = 1'b1;
                            state_d    = ST_RUN;
                        end else if (dump_words_q != '0) begin
                            state_d = ST_DREQ;
                        end else begin
                            state_d = ST_DONE;
                        end
                    end
                end
            end
            ST_RUN: begin
                if (timer_expired) begin
                    state_d = (dump_words_q != '0) ? ST_DREQ : ST_DONE;
                end
            end
            ST_DREQ: begin
                state_d = ST_DWAIT;
            end
            ST_DWAIT: begin
                m_data_d = bus.dmem_rdata;
                state_d  = ST_DOUT;
            end
            ST_DOUT: begin
                if (bus.m_ready) begin
                    dump_idx_d = dump_idx_q + DUMP_W'(1);
                    state_d    = dump_last_c ? ST_DONE : ST_DREQ;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            run_cycles_q <= '0;
            dump_words_q <= '0;
            word_cnt_q   <= '0;
            dump_idx_q   <= '0;
            m_data_q     <= '0;
            load_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            run_cycles_q <= run_cycles_d;
            dump_words_q <= dump_words_d;
            word_cnt_q   <= word_cnt_d;
            dump_idx_q   <= dump_idx_d;
            m_data_q     <= m_data_d;
            load_err_q   <= load_err_d;
        end
    end

    // imem write is combinational from the stream so it lands in the handshake cycle
    assign bus.s_ready    = s_ready_c;
    assign bus.imem_wen   = s_hs_c && word_fits_c;
    assign bus.imem_addr  = bus.imem_wen ? (ADDR_W'(word_cnt_q) * ADDR_W'(IMEM_STRIDE)) : '0;
    assign bus.imem_wdata = bus.imem_wen ? bus.s_data : '0;
    assign bus.imem_ren   = 1'b0;

    assign bus.dmem_ren   = (state_q == ST_DREQ);
    assign bus.dmem_addr  = bus.dmem_ren ? (ADDR_W'(dump_idx_q) * ADDR_W'(DMEM_STRIDE)) : '0;
    assign bus.dmem_wen   = 1'b0;
    assign bus.dmem_wdata = '0;

    assign bus.m_valid    = (state_q == ST_DOUT);
    assign bus.m_last     = bus.m_valid && dump_last_c;
    assign bus.m_data     = m_data_q;

    assign cpu_enable = (state_q == ST_RUN);
    assign busy       = (state_q != ST_IDLE) && (state_q != ST_DONE);
    assign done       = (state_q == ST_DONE);
    assign load_err   = load_err_q;

endmodule

// File: tb/tb_cpu_test_loader.sv
// Directed bench for cpu_test_loader with a synchronous dmem model and event logs.
module tb_cpu_test_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] run_cycles;
    logic [10:0] dump_words;
    logic        cpu_enable, busy, done, load_err;

    cpu_test_loader_if bus ();

    cpu_test_loader dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .run_cycles (run_cycles),
        .dump_words (dump_words),
        .cpu_enable (cpu_enable),
        .busy       (busy),
        .done       (done),
        .load_err   (load_err),
        .bus        (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int hs_last_cyc = 0;

    logic [63:0] wr_addr[$];
    logic [31:0] wr_data[$];
    int          wr_cyc[$];
    int          en_cyc[$];
    int          ren_cyc[$];
    logic [63:0] ren_addr[$];
    logic [63:0] m_dat[$];
    logic        m_lst[$];
    int          m_cyc[$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] gen_word(input int i);
        case (i)
            0:       return 32'h0050_0093;
            1:       return 32'h00A0_0113;
            2:       return 32'h0020_81B3;
            default: return 32'hC0DE_0000 | 32'(i);
        endcase
    endfunction

    // Synchronous SRAM: word k holds 0x11*(k+1)
    always @(posedge clk) begin
        if (bus.dmem_ren) begin
            bus.dmem_rdata <= 64'h11 * (64'(bus.dmem_addr[6:3]) + 64'd1);
        end
    end

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.imem_wen) begin
            wr_addr.push_back(bus.imem_addr);
            wr_data.push_back(bus.imem_wdata);
            wr_cyc.push_back(cyc);
        end
        if (bus.s_valid && bus.s_ready && bus.s_last) hs_last_cyc <= cyc;
        if (cpu_enable) en_cyc.push_back(cyc);
        if (bus.dmem_ren) begin
            ren_cyc.push_back(cyc);
            ren_addr.push_back(bus.dmem_addr);
        end
        if (bus.m_valid && bus.m_ready) begin
            m_dat.push_back(bus.m_data);
            m_lst.push_back(bus.m_last);
            m_cyc.push_back(cyc);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_ctl"}, 64'({bus.s_ready, bus.m_valid, bus.m_last, cpu_enable, bus.imem_wen,
                                bus.imem_ren, bus.dmem_ren, bus.dmem_wen, busy, done, load_err}), 64'd0);
        chk({tag, "_bus"}, bus.imem_addr | bus.dmem_addr | bus.m_data | bus.dmem_wdata |
                           64'(bus.imem_wdata), 64'd0);
    endtask

    task automatic do_start(input logic [31:0] rc, input logic [10:0] dw);
        run_cycles = rc;
        dump_words = dw;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic load_words(input int n);
        for (int i = 0; i < n; i++) begin
            bus.s_valid = 1'b1;
            bus.s_data  = gen_word(i);
            bus.s_last  = (i == n - 1);
            tick();
        end
        bus.s_valid = 1'b0;
        bus.s_last  = 1'b0;
        bus.s_data  = '0;
    endtask

    task automatic wait_done(input string tag, input int max);
        int t = 0;
        while (!done && t < max) begin
            tick();
            t++;
        end
        chk(tag, 64'(done), 64'd1);
    endtask

    initial begin
        int bw, be, br, bm, bad, t;
        rst = 1'b1; start = 1'b0; run_cycles = '0; dump_words = '0;
        bus.s_valid = 1'b0; bus.s_data = '0; bus.s_last = 1'b0; bus.m_ready = 1'b0;
        @(posedge clk); @(posedge clk); @(negedge clk);
        chk_idle("rst");
        tick();
        rst = 1'b0;

        // Load 3 words, run 5 cycles, dump 2 words with m_ready high
        bus.m_ready = 1'b1;
        bw = wr_addr.size(); be = en_cyc.size(); br = ren_cyc.size(); bm = m_dat.size();
        do_start(32'd5, 11'd2);
        chk("start_rdy", 64'(bus.s_ready), 64'd1);
        load_words(3);
        wait_done("t1_done", 40);
        chk("t1_rdy_low", 64'(bus.s_ready), 64'd0);
        chk("t1_wr_n", 64'(wr_addr.size() - bw), 64'd3);
        for (int i = 0; i < 3; i++) begin
            chk("t1_wr_addr", wr_addr[bw + i], 64'(4 * i));
            chk("t1_wr_data", 64'(wr_data[bw + i]), 64'(gen_word(i)));
        end
        chk("t1_wr_consec", 64'(wr_cyc[bw + 2] - wr_cyc[bw]), 64'd2);
        chk("t1_en_n", 64'(en_cyc.size() - be), 64'd5);
        chk("t1_en_lat", 64'(en_cyc[be] - hs_last_cyc), 64'd1);
        chk("t1_en_span", 64'(en_cyc[en_cyc.size() - 1] - en_cyc[be]), 64'd4);
        chk("t1_ren_n", 64'(ren_cyc.size() - br), 64'd2);
        chk("t1_ren_lat", 64'(ren_cyc[br] - en_cyc[en_cyc.size() - 1]), 64'd1);
        chk("t1_ren_addr1", ren_addr[br + 1], 64'd8);
        chk("t1_m_n", 64'(m_dat.size() - bm), 64'd2);
        chk("t1_m_d0", m_dat[bm], 64'h11);
        chk("t1_m_d1", m_dat[bm + 1], 64'h22);
        chk("t1_m_last", 64'({m_lst[bm], m_lst[bm + 1]}), 64'b01);
        chk("t1_mv_lat", 64'(m_cyc[bm] - ren_cyc[br]), 64'd2);
        chk("t1_m_thru", 64'(m_cyc[bm + 1] - m_cyc[bm]), 64'd3);
        chk("t1_busy", 64'({busy, load_err}), 64'd0);

        // Hold m_ready low for 10 cycles in DOUT
        bus.m_ready = 1'b0;
        bm = m_dat.size();
        do_start(32'd2, 11'd1);
        load_words(1);
        t = 0;
        while (!bus.m_valid && t < 20) begin
            tick();
            t++;
        end
        chk("st_reach", 64'(bus.m_valid), 64'd1);
        br = ren_cyc.size();
        repeat (10) begin
            @(negedge clk);
            chk("st_valid", 64'(bus.m_valid), 64'd1);
            chk("st_data", bus.m_data, 64'h11);
            chk("st_last", 64'(bus.m_last), 64'd1);
        end
        chk("st_no_ren", 64'(ren_cyc.size() - br), 64'd0);
        tick();
        bus.m_ready = 1'b1;
        wait_done("st_done", 10);
        chk("st_m_n", 64'(m_dat.size() - bm), 64'd1);
        chk("st_m_d", m_dat[bm], 64'h11);

        // 513 words: the last one is dropped and flags load_err
        bw = wr_addr.size(); be = en_cyc.size(); br = ren_cyc.size();
        do_start(32'd1, 11'd0);
        load_words(513);
        wait_done("ov_done", 10);
        chk("ov_wr_n", 64'(wr_addr.size() - bw), 64'd512);
        bad = 0;
        for (int i = 0; i < 512; i++) begin
            if (bw + i >= wr_addr.size()) bad++;
            else if (wr_addr[bw + i] != 64'(4 * i) || wr_data[bw + i] != gen_word(i)) bad++;
        end
        chk("ov_wr_bad", 64'(bad), 64'd0);
        chk("ov_last_addr", wr_addr[bw + 511], 64'd2044);
        chk("ov_err", 64'(load_err), 64'd1);
        chk("ov_en_n", 64'(en_cyc.size() - be), 64'd1);
        chk("ov_ren_n", 64'(ren_cyc.size() - br), 64'd0);

        // Reset during RUN; a start pulse in RUN is ignored first
        do_start(32'd100, 11'd1);
        chk("rr_err_clr", 64'(load_err), 64'd0);
        load_words(1);
        repeat (3) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        @(negedge clk);
        chk("rr_ign", 64'({cpu_enable, busy, bus.s_ready}), 64'b110);
        tick();
        rst = 1'b1;
        tick();
        chk_idle("rr");
        rst = 1'b0;

        // Zero run and zero dump: LOAD straight to DONE
        bw = wr_addr.size(); be = en_cyc.size(); br = ren_cyc.size();
        do_start(32'd0, 11'd0);
        load_words(2);
        @(negedge clk);
        chk("zc_state", 64'({done, busy}), 64'b10);
        chk("zc_wr_n", 64'(wr_addr.size() - bw), 64'd2);
        chk("zc_en_n", 64'(en_cyc.size() - be), 64'd0);
        chk("zc_ren_n", 64'(ren_cyc.size() - br), 64'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
